tff_toggle_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit bank of T flip-flops between NREQ requesters. Each requester presents a toggle mask. The arbiter grants one requester per clock and applies that requester's mask as the T inputs of the bank for that edge. It sits between independent control agents and the shared toggle register, and is the only block that drives the bank's T inputs.

---
 rtl/tff_toggle_arbiter.sv | 66 ++++++
 tb/tb_tff_toggle_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter granting one requester per edge to toggle a shared T-flop bank.
// Latency: grant and q update at the sampling edge; hold blocks that edge's grant, requests wait.
`timescale 1ns/1ps
module tff_toggle_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   mask,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        q,
  output logic [15:0]             grant_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    nxt_ptr;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  win_onehot;
  logic [WIDTH-1:0] win_mask;
  logic             win_vld;
  int               idx;

  assign elig = hold ? '0 : req;

  // Rotating scan from ptr; the first eligible requester wins and the pointer moves past it.
  always_comb begin
    win_vld    = 1'b0;
    win_onehot = '0;
    win_mask   = '0;
    nxt_ptr    = ptr;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!win_vld && elig[idx]) begin
        win_vld         = 1'b1;
        win_onehot[idx] = 1'b1;
        nxt_ptr         = PW'((idx + 1) % NREQ);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (win_onehot[k]) win_mask = mask[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q           <= '0;
      ptr         <= '0;
      gnt         <= '0;
      grant_count <= '0;
    end else begin
      gnt <= win_onehot;
      if (win_vld) begin
        q           <= q ^ win_mask;
        ptr         <= nxt_ptr;
        grant_count <= grant_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
`timescale 1ns/1ps
module tb_tff_toggle_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  hold = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] mask = '0;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [15:0]           grant_count;

  tff_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .hold(hold), .req(req), .mask(mask),
    .gnt(gnt), .q(q), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0]  g;
    logic [WIDTH-1:0] q;
    logic [15:0]      c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;

  // Reference state: priority index, bank contents, grant tally.
  int               m_ptr;
  logic [WIDTH-1:0] m_q;
  logic [15:0]      m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_q   = '0;
    m_cnt = '0;
  endtask

  function automatic logic [NREQ*WIDTH-1:0] pack4(input logic [7:0] m0, input logic [7:0] m1,
                                                  input logic [7:0] m2, input logic [7:0] m3);
    return {m3, m2, m1, m0};
  endfunction

  // Drive one cycle of inputs and predict what the next edge produces.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] mb, input logic h);
    int   w;
    exp_t e;
    @(negedge clk);
    req  = r;
    mask = mb;
    hold = h;
    w = -1;
    if (!h) begin
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
    end
    e.g = '0;
    if (w >= 0) begin
      m_q   = m_q ^ mb[w*WIDTH +: WIDTH];
      e.g[w] = 1'b1;
      m_ptr = (w + 1) % NREQ;
      m_cnt = m_cnt + 16'd1;
    end
    e.q = m_q;
    e.c = m_cnt;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("gnt", 32'(gnt), 32'(mon_e.g));
      chk("q", 32'(q), 32'(mon_e.q));
      chk("grant_count", 32'(grant_count), 32'(mon_e.c));
    end
  end

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("reset_q", 32'(q), 0);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_count", 32'(grant_count), 0);

    req  = 4'b1111;
    mask = pack4(8'h11, 8'h22, 8'h44, 8'h88);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset_held_q", 32'(q), 0);
      chk("reset_held_gnt", 32'(gnt), 0);
      chk("reset_held_count", 32'(grant_count), 0);
    end
    @(negedge clk);
    req   = '0;
    reset = 1'b0;

    // Single requester toggling the same bits every cycle.
    repeat (3) step(4'b0010, pack4(8'hAA, 8'h0F, 8'h55, 8'hFF), 1'b0);

    // All requesting: rotation must visit 0,1,2,3 twice.
    repeat (8) step(4'b1111, pack4(8'h01, 8'h02, 8'h04, 8'h08), 1'b0);

    // hold blocks grants, then release.
    repeat (3) step(4'b0100, pack4(8'h00, 8'h00, 8'h3C, 8'h00), 1'b1);
    step(4'b0100, pack4(8'h00, 8'h00, 8'h3C, 8'h00), 1'b0);

    // Zero mask still counts as a grant.
    repeat (3) step(4'b0001, pack4(8'h00, 8'hFF, 8'hFF, 8'hFF), 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), NREQ*WIDTH'($urandom), ($urandom_range(0, 3) == 0));
    end
    step(4'b0000, '0, 1'b0);

    // Asynchronous reset in the middle of a full-request stream.
    repeat (3) step(4'b1111, pack4(8'h01, 8'h02, 8'h04, 8'h08), 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_q", 32'(q), 0);
    chk("midreset_gnt", 32'(gnt), 0);
    chk("midreset_count", 32'(grant_count), 0);
    model_reset();
    #1 reset = 1'b0;
    repeat (2) step(4'b1111, pack4(8'h01, 8'h02, 8'h04, 8'h08), 1'b0);

    // Counter wrap: reset, then 65534 grants, then two more.
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    for (int i = 0; i < 65534; i++) step(4'b0001, '0, 1'b0);
    @(posedge clk);
    #2;
    chk("preload_count", 32'(grant_count), 32'h0000FFFE);
    step(4'b0001, '0, 1'b0);
    step(4'b0001, '0, 1'b0);
    step(4'b0000, '0, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    chk("wrap_count", 32'(grant_count), 32'h00000000);
    chk("queue_drain", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
